// File: rtl/ench_limp_timer_ctrl.sv
// ench_limp_timer_ctrl: tank CLEAN-then-FILL sequencer timed by a two-digit BCD seconds down-counter.
// Optional macro ENCH_LIMP_PAUSE_EN adds a pause input that freezes the count and closes both valves.
module ench_limp_timer_ctrl #(
  parameter int unsigned CLEAN_TENS  = 1,
  parameter int unsigned CLEAN_UNITS = 0,
  parameter int unsigned FILL_TENS   = 3,
  parameter int unsigned FILL_UNITS  = 0
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       tick,
`ifdef ENCH_LIMP_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       start,
  input  logic       abort,
  input  logic       level_empty,
  input  logic       level_full,
  output logic       drain_valve,
  output logic       fill_valve,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAN = 2'b01,
    ST_FILL  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  if (CLEAN_TENS > 3 || CLEAN_UNITS > 9 || FILL_TENS > 3 || FILL_UNITS > 9) begin : g_bad_cfg
    $fatal(1, "ench_limp_timer_ctrl: phase duration digits out of BCD range");
  end

  localparam logic [1:0] LP_CLEAN_TENS  = 2'(CLEAN_TENS);
  localparam logic [3:0] LP_CLEAN_UNITS = 4'(CLEAN_UNITS);
  localparam logic [1:0] LP_FILL_TENS   = 2'(FILL_TENS);
  localparam logic [3:0] LP_FILL_UNITS  = 4'(FILL_UNITS);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [1:0] r_tens;
  logic [1:0] w_tens_nxt;
  logic [3:0] r_units;
  logic [3:0] w_units_nxt;
  logic       r_drain_valve;
  logic       r_fill_valve;
  logic       r_busy;
  logic       r_done;
  logic       w_pause;
  logic       w_cnt_zero;
  logic       w_dec_en;

`ifdef ENCH_LIMP_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_cnt_zero = (r_tens == 2'd0) && (r_units == 4'd0);
  assign w_dec_en   = tick && !w_pause && !w_cnt_zero;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_tens_nxt  = r_tens;
    w_units_nxt = r_units;
    unique case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = ST_CLEAN;
          w_tens_nxt  = LP_CLEAN_TENS;
          w_units_nxt = LP_CLEAN_UNITS;
        end
      end
      ST_CLEAN, ST_FILL: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_tens_nxt  = 2'd0;
          w_units_nxt = 4'd0;
        end else if (r_state == ST_CLEAN && (w_cnt_zero || level_empty)) begin
          w_state_nxt = ST_FILL;
          w_tens_nxt  = LP_FILL_TENS;
          w_units_nxt = LP_FILL_UNITS;
        end else if (r_state == ST_FILL && (w_cnt_zero || level_full)) begin
          w_state_nxt = ST_DONE;
          w_tens_nxt  = 2'd0;
          w_units_nxt = 4'd0;
        end else if (w_dec_en) begin
          // BCD borrow: units wrap 0 -> 9 and take one from tens.
          if (r_units == 4'd0) begin
            w_units_nxt = 4'd9;
            w_tens_nxt  = r_tens - 2'd1;
          end else begin
            w_units_nxt = r_units - 4'd1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_tens_nxt  = 2'd0;
        w_units_nxt = 4'd0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the async clear clears every flop, valves included, without waiting for an edge.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state       <= ST_IDLE;
      r_tens        <= 2'd0;
      r_units       <= 4'd0;
      r_drain_valve <= 1'b0;
      r_fill_valve  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tens        <= w_tens_nxt;
      r_units       <= w_units_nxt;
      r_drain_valve <= (w_state_nxt == ST_CLEAN) && !w_pause;
      r_fill_valve  <= (w_state_nxt == ST_FILL) && !w_pause;
      r_busy        <= (w_state_nxt == ST_CLEAN) || (w_state_nxt == ST_FILL);
      r_done        <= (w_state_nxt == ST_DONE);
    end
  end

  assign drain_valve = r_drain_valve;
  assign fill_valve  = r_fill_valve;
  assign busy        = r_busy;
  assign done        = r_done;
  assign tens        = {2'b00, r_tens};
  assign units       = r_units;
  assign phase       = r_state;

endmodule
